// File: rtl/cost_matrix_cache_pkg.sv
// ---------------------------------------------------------------------------
// cost_matrix_cache_pkg
// Shared definitions for the cost matrix cache and its adder tree.
//   N       : workers = jobs (8), each indexed by IDX_W bits
//   COST_W  : width of one cost entry
//   SUM_W   : width of a full permutation total (8 x 255 fits in 11 bits)
//   PAIR_W  : width of a pairwise partial sum
//   ADDR_W  : width of the {worker, job} sweep address
//   PERM_W  : width of a packed permutation (job for worker i at 3i+2:3i)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package cost_matrix_cache_pkg;

    localparam int N      = 8;
    localparam int COST_W = 8;
    localparam int SUM_W  = 11;
    localparam int IDX_W  = 3;
    localparam int PAIR_W = COST_W + 1;
    localparam int ADDR_W = 2 * IDX_W;
    localparam int PERM_W = N * IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY
    } state_t;

    // Pulls the job index assigned to worker i out of a packed permutation.
    function automatic logic [IDX_W-1:0] permField(input logic [PERM_W-1:0] p,
                                                   input int i);
        return p[i*IDX_W +: IDX_W];
    endfunction

endpackage

// File: rtl/cost_matrix_cache_sum_tree.sv
// ---------------------------------------------------------------------------
// cost_sum_tree
// Two-stage registered adder tree: eight costs in, one total out.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   i_valid  : the eight costs belong to an accepted query
//   i_costs  : eight COST_W costs, one per worker
//   o_valid  : total-cost strobe, two cycles after i_valid
//   o_sum    : total cost, holds its last value while o_valid is low
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module cost_sum_tree
    import cost_matrix_cache_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    input  logic [N-1:0][COST_W-1:0]   i_costs,
    output logic                       o_valid,
    output logic [SUM_W-1:0]           o_sum
);

    logic [3:0][PAIR_W-1:0] r_pair;
    logic                   r_valid1;
    logic [SUM_W-1:0]       r_sum;
    logic                   r_valid2;

    // First stage adds neighbouring workers in pairs; the pair registers only
    // move on a valid query so the tree is quiet between queries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pair   <= '0;
            r_valid1 <= 1'b0;
        end else begin
            r_valid1 <= i_valid;
            if (i_valid) begin
                for (int p = 0; p < 4; p++) begin
                    r_pair[p] <= PAIR_W'(i_costs[2*p]) + PAIR_W'(i_costs[2*p+1]);
                end
            end
        end
    end

    // Second stage folds the four pairs into the final total; the total is
    // only overwritten by a valid result so it holds between results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum    <= '0;
            r_valid2 <= 1'b0;
        end else begin
            r_valid2 <= r_valid1;
            if (r_valid1) begin
                r_sum <= SUM_W'(r_pair[0]) + SUM_W'(r_pair[1]) +
                         SUM_W'(r_pair[2]) + SUM_W'(r_pair[3]);
            end
        end
    end

    assign o_valid = r_valid2;
    assign o_sum   = r_sum;

endmodule

// File: rtl/cost_matrix_cache.sv
// ---------------------------------------------------------------------------
// cost_matrix_cache
// Sweeps the external W/J -> Cost lookup once after start, keeps all 64 costs
// in a local matrix, then totals one full permutation per cycle (latency 2).
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   start      : one-cycle pulse, begins a (re)load of the matrix
//   W, J       : registered worker/job of the current external request
//   Cost       : external cost for the W/J driven in the previous cycle
//   ready      : matrix loaded, queries accepted
//   perm_valid : query strobe
//   perm       : job for worker i in bits [3i+2:3i]
//   sum_valid  : total-cost strobe
//   sum        : total cost of the queried permutation
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module cost_matrix_cache
    import cost_matrix_cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [IDX_W-1:0]    W,
    output logic [IDX_W-1:0]    J,
    input  logic [COST_W-1:0]   Cost,
    output logic                ready,
    input  logic                perm_valid,
    input  logic [PERM_W-1:0]   perm,
    output logic                sum_valid,
    output logic [SUM_W-1:0]    sum
);

    state_t                     r_state;
    state_t                     w_nextState;
    logic                       w_loadStart;
    logic [ADDR_W-1:0]          r_addr;
    logic                       r_sweepDone;
    logic                       r_capEn;
    logic [ADDR_W-1:0]          r_capAddr;
    logic [COST_W-1:0]          r_matrix [0:N*N-1];
    logic [N-1:0][COST_W-1:0]   w_costs;
    logic                       w_accept;

    // State register for the load/serve controller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. start is honoured in IDLE and READY only; LOAD runs
    // to completion and leaves once the final capture cycle has happened.
    always_comb begin
        w_nextState = r_state;
        w_loadStart = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = LOAD;
                    w_loadStart = 1'b1;
                end
            end
            LOAD: begin
                if (r_sweepDone) begin
                    w_nextState = READY;
                end
            end
            READY: begin
                if (start) begin
                    w_nextState = LOAD;
                    w_loadStart = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Sweep address and capture pointer. The external Cost answers the address
    // of the previous cycle, so the address is delayed by one cycle before it
    // is used as the write pointer. After address 63 the counter holds and one
    // more capture cycle runs before the controller enters READY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_sweepDone <= 1'b0;
            r_capEn     <= 1'b0;
            r_capAddr   <= '0;
        end else begin
            r_capEn   <= (r_state == LOAD) && !r_sweepDone;
            r_capAddr <= r_addr;
            if (w_loadStart) begin
                r_addr      <= '0;
                r_sweepDone <= 1'b0;
            end else if ((r_state == LOAD) && !r_sweepDone) begin
                if (r_addr == '1) begin
                    r_sweepDone <= 1'b1;
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

    // Matrix storage has no reset; its contents are meaningless until a sweep
    // has completed, and the capture enable itself is reset.
    always_ff @(posedge clk) begin
        if (r_capEn) begin
            r_matrix[r_capAddr] <= Cost;
        end
    end

    // Row i of the matrix is indexed by the job that the permutation gives
    // worker i.
    always_comb begin
        w_costs = '0;
        for (int i = 0; i < N; i++) begin
            w_costs[i] = r_matrix[{IDX_W'(i), permField(perm, i)}];
        end
    end

    assign W        = r_addr[ADDR_W-1:IDX_W];
    assign J        = r_addr[IDX_W-1:0];
    assign ready    = (r_state == READY);
    assign w_accept = ready && perm_valid;

    cost_sum_tree u_sumTree (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_accept),
        .i_costs (w_costs),
        .o_valid (sum_valid),
        .o_sum   (sum)
    );

endmodule

// File: tb/tb_cost_matrix_cache.sv
// ---------------------------------------------------------------------------
// tb_cost_matrix_cache
// Bench for cost_matrix_cache: an external cost memory answering W/J one
// cycle late, a reference matrix copied from that memory when a load is
// complete, and a scoreboard of expected totals checked by a monitor.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cost_matrix_cache;
    import cost_matrix_cache_pkg::*;

    localparam logic [23:0] PERM_ID  = 24'hFAC688;
    localparam logic [23:0] PERM_REV = 24'h053977;

    typedef struct {
        int sumExp;
        int cycExp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  W;
    logic [2:0]  J;
    logic [7:0]  Cost;
    logic        ready;
    logic        perm_valid;
    logic [23:0] perm;
    logic        sum_valid;
    logic [10:0] sum;

    int          assertCount = 0;
    int          failCount   = 0;
    int          cycCount    = 0;
    bit          modelReady  = 1'b0;
    logic [7:0]  extMem [64];
    logic [7:0]  refM   [64];
    logic [5:0]  lastAddr = '0;
    exp_t        sbQ [$];

    cost_matrix_cache dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .W          (W),
        .J          (J),
        .Cost       (Cost),
        .ready      (ready),
        .perm_valid (perm_valid),
        .perm       (perm),
        .sum_valid  (sum_valid),
        .sum        (sum)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used to check result latency.
    always @(posedge clk) cycCount++;

    // External lookup: Cost in a cycle answers the W/J seen in the previous one.
    always @(negedge clk) begin
        Cost     = extMem[lastAddr];
        lastAddr = {W, J};
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Total cost straight from the rule: sum over workers of M[i][perm_i].
    function automatic int modelSum(input logic [23:0] p);
        int s = 0;
        for (int i = 0; i < 8; i++) begin
            s += int'(refM[i*8 + int'(p[3*i +: 3])]);
        end
        return s;
    endfunction

    // Monitor: every result the DUT presents must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && sum_valid === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedSum", sbQ.size(), 1);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("sum", sum, e.sumExp);
                checkOutput("latency", cycCount, e.cycExp);
            end
        end
    end

    // Drive one query for the coming edge, optionally together with start.
    task automatic applyStimulus(input logic [23:0] p, input bit withStart);
        exp_t e;
        @(negedge clk);
        perm_valid = 1'b1;
        perm       = p;
        start      = withStart;
        if (modelReady) begin
            e.sumExp = modelSum(p);
            e.cycExp = cycCount + 2;
            sbQ.push_back(e);
        end
    endtask

    task automatic drain(input int cycles);
        @(negedge clk);
        perm_valid = 1'b0;
        start      = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    // Full load: pulse start, follow the W/J sweep, measure the ready latency.
    task automatic doLoad(input bit noisy, input bit withQuery);
        int n;
        if (withQuery) begin
            applyStimulus(PERM_ID, 1'b1);
        end else begin
            @(negedge clk);
            perm_valid = 1'b0;
            start      = 1'b1;
        end
        modelReady = 1'b0;
        @(posedge clk);
        #1;
        start      = 1'b0;
        perm_valid = 1'b0;
        checkOutput("wjFirst", {26'd0, W, J}, 0);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) checkOutput("readyLow", ready, 0);
            if (n < 64) checkOutput("wjSeq", {26'd0, W, J}, n);
            if (n == 64) checkOutput("wjHold", {26'd0, W, J}, 63);
            if (ready === 1'b1) break;
            if (noisy) begin
                perm_valid = 1'($urandom_range(0, 1));
                perm       = 24'($urandom);
            end
        end
        perm_valid = 1'b0;
        checkOutput("readyLatency", n, 65);
        if (ready === 1'b1) begin
            for (int a = 0; a < 64; a++) refM[a] = extMem[a];
            modelReady = 1'b1;
        end
    endtask

    // Asynchronous reset at an arbitrary point, checked before the next edge.
    task automatic midReset(input string tag);
        rst = 1'b1;
        #1;
        checkOutput({tag, "Ready"}, ready, 0);
        checkOutput({tag, "W"}, W, 0);
        checkOutput({tag, "J"}, J, 0);
        checkOutput({tag, "SumValid"}, sum_valid, 0);
        checkOutput({tag, "Sum"}, sum, 0);
        sbQ.delete();
        modelReady = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        perm_valid = 1'b0;
        perm       = '0;
        for (int a = 0; a < 64; a++) extMem[a] = '0;
        for (int a = 0; a < 64; a++) refM[a] = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstReady", ready, 0);
        checkOutput("rstW", W, 0);
        checkOutput("rstJ", J, 0);
        checkOutput("rstSumValid", sum_valid, 0);
        checkOutput("rstSum", sum, 0);
        @(negedge clk);
        rst = 1'b0;

        // Queries while idle must be ignored.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            perm_valid = 1'b1;
            perm       = 24'($urandom);
        end
        drain(2);

        // Reset during load cycle 30, then a complete reload.
        for (int a = 0; a < 64; a++) extMem[a] = 8'($urandom);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        midReset("loadRst");
        doLoad(1'b1, 1'b0);
        applyStimulus(PERM_ID, 1'b0);
        applyStimulus(24'($urandom), 1'b0);
        drain(4);

        // Product matrix: identity, then reverse/identity/reverse back to back.
        for (int a = 0; a < 64; a++) extMem[a] = 8'((a / 8) * (a % 8));
        doLoad(1'b0, 1'b0);
        applyStimulus(PERM_ID, 1'b0);
        drain(4);
        applyStimulus(PERM_REV, 1'b0);
        applyStimulus(PERM_ID, 1'b0);
        applyStimulus(PERM_REV, 1'b0);
        drain(4);

        // Random matrices with random query traffic, including repeated jobs.
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < 64; a++) extMem[a] = 8'($urandom);
            doLoad(1'b1, 1'b0);
            for (int k = 0; k < 40; k++) begin
                if ($urandom_range(0, 3) != 0) begin
                    applyStimulus(24'($urandom), 1'b0);
                end else begin
                    @(negedge clk);
                    perm_valid = 1'b0;
                end
            end
            drain(4);
        end

        // Saturated costs: every total is 2040 with no wrap.
        for (int a = 0; a < 64; a++) extMem[a] = 8'd255;
        doLoad(1'b0, 1'b0);
        for (int k = 0; k < 10; k++) applyStimulus(24'($urandom), 1'b0);
        drain(4);

        // Query together with start reads the old matrix; reload with zeros.
        for (int a = 0; a < 64; a++) extMem[a] = 8'((a / 8) * (a % 8));
        doLoad(1'b0, 1'b0);
        for (int a = 0; a < 64; a++) extMem[a] = 8'd0;
        doLoad(1'b0, 1'b1);
        applyStimulus(PERM_ID, 1'b0);
        drain(4);

        // Reset with a query in flight: the result must never appear.
        for (int a = 0; a < 64; a++) extMem[a] = 8'($urandom);
        doLoad(1'b0, 1'b0);
        applyStimulus(PERM_ID, 1'b0);
        @(posedge clk);
        #1;
        midReset("queryRst");
        drain(6);

        checkOutput("sbDrained", sbQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
